// File: rtl/video_proc_pkg.sv
// Shared encodings for the Y-channel point-operation stage: pixel modes and
// the frame-synchronisation FSM states.
package video_proc_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_INV     = 2'd1,
        MODE_BIN     = 2'd2,
        MODE_BIN_INV = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACTIVE    = 2'd2
    } state_e;

    // Next mode in the auto-cycle sequence; wraps from inverted binary to bypass.
    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/video_mode_scheduler_y_point_op.sv
// Combinational luma point operation: bypass, invert, binarize or inverted
// binarize against a threshold. The parent owns all registering.
module y_point_op
    import video_proc_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [7:0] thresh,
    input  logic [7:0] y_in,
    output logic [7:0] y_out
);

    logic at_or_above;

    assign at_or_above = (y_in >= thresh);

    // Select the transformed luma for the requested mode.
    always_comb begin
        // NOTE: y_out gets a value before the case so every path assigns it and no latch is inferred.
        y_out = y_in;
        unique case (mode_e'(mode))
            MODE_BYPASS:  y_out = y_in;
            MODE_INV:     y_out = 8'hFF - y_in;
            MODE_BIN:     y_out = at_or_above ? 8'hFF : 8'h00;
            MODE_BIN_INV: y_out = at_or_above ? 8'h00 : 8'hFF;
            default:      y_out = y_in;
        endcase
    end

endmodule

// File: rtl/video_mode_scheduler.sv
// Frame-synchronous mode/threshold scheduler for the Y point-operation stage.
// Configuration requests are held in a one-entry slot and only take effect at
// a vsync rising edge, so every frame is processed with a single setting.
module video_mode_scheduler
    import video_proc_pkg::*;
#(
    parameter int unsigned AUTO_FRAMES = 60,
    parameter logic [7:0]  INIT_THRESH = 8'd128,
    parameter logic [1:0]  INIT_MODE   = 2'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    input  logic       cfg_valid,
    input  logic [1:0] cfg_mode,
    input  logic [7:0] cfg_thresh,
    output logic       cfg_ready,
    input  logic       auto_en,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_Y,
    output logic [1:0] cur_mode,
    output logic [15:0] frame_cnt
);

    localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);

    state_e      state_q, state_d;
    logic        vsync_prev_q, vsync_prev_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    mode_e       cur_mode_q, cur_mode_d;
    logic [7:0]  thresh_q, thresh_d;
    logic        pend_full_q, pend_full_d;
    mode_e       pend_mode_q, pend_mode_d;
    logic [7:0]  pend_thresh_q, pend_thresh_d;
    logic [15:0] auto_cnt_q, auto_cnt_d;
    logic        post_vsync_q, post_vsync_d;
    logic        post_href_q, post_href_d;
    logic        post_clken_q, post_clken_d;
    logic [7:0]  post_y_q, post_y_d;

    logic        frame_start;
    logic        cfg_fire;
    logic        gated;
    logic [7:0]  op_y;

    // The slot is reported empty only once reset has been released.
    assign cfg_ready   = rst_n & ~pend_full_q;
    assign cfg_fire    = cfg_valid & cfg_ready;
    assign frame_start = (state_q == ST_IDLE) & ~vsync_prev_q & per_frame_vsync;
    assign gated       = (state_q == ST_WAIT_SYNC);

    // The pixel op sees the settings being installed this cycle, so the
    // frame-start pixel already uses the new frame's mode.
    y_point_op u_point_op (
        .mode   (cur_mode_d),
        .thresh (thresh_d),
        .y_in   (per_img_Y),
        .y_out  (op_y)
    );

    // Next-state logic: frame FSM, frame-start updates, handshake and datapath.
    always_comb begin
        state_d       = state_q;
        vsync_prev_d  = per_frame_vsync;
        frame_cnt_d   = frame_cnt_q;
        cur_mode_d    = cur_mode_q;
        thresh_d      = thresh_q;
        pend_full_d   = pend_full_q;
        pend_mode_d   = pend_mode_q;
        pend_thresh_d = pend_thresh_q;
        auto_cnt_d    = auto_cnt_q;

        unique case (state_q)
            ST_WAIT_SYNC: if (!per_frame_vsync) state_d = ST_IDLE;
            ST_IDLE:      if (frame_start)      state_d = ST_ACTIVE;
            ST_ACTIVE:    if (vsync_prev_q && !per_frame_vsync) state_d = ST_IDLE;
            default:      state_d = ST_WAIT_SYNC;
        endcase

        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (pend_full_q) begin
                cur_mode_d  = pend_mode_q;
                thresh_d    = pend_thresh_q;
                pend_full_d = 1'b0;
                auto_cnt_d  = 16'd0;
            end else if (auto_en && (auto_cnt_q == AUTO_LAST)) begin
                cur_mode_d = next_mode(cur_mode_q);
                auto_cnt_d = 16'd0;
            end else if (auto_en) begin
                auto_cnt_d = auto_cnt_q + 16'd1;
            end
        end

        if (!auto_en) auto_cnt_d = 16'd0;

        // A transfer needs an empty slot, so it never collides with the
        // frame-start clear above; a same-cycle request waits a full frame.
        if (cfg_fire) begin
            pend_full_d   = 1'b1;
            pend_mode_d   = mode_e'(cfg_mode);
            pend_thresh_d = cfg_thresh;
        end

        post_vsync_d = per_frame_vsync & ~gated;
        post_href_d  = per_frame_href  & ~gated;
        post_clken_d = per_frame_clken & ~gated;
        post_y_d     = (per_frame_clken && !gated) ? op_y : 8'h00;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q       <= ST_WAIT_SYNC;
            vsync_prev_q  <= 1'b0;
            frame_cnt_q   <= 16'd0;
            cur_mode_q    <= mode_e'(INIT_MODE);
            thresh_q      <= INIT_THRESH;
            pend_full_q   <= 1'b0;
            pend_mode_q   <= MODE_BYPASS;
            pend_thresh_q <= 8'd0;
            auto_cnt_q    <= 16'd0;
            post_vsync_q  <= 1'b0;
            post_href_q   <= 1'b0;
            post_clken_q  <= 1'b0;
            post_y_q      <= 8'd0;
        end else begin
            state_q       <= state_d;
            vsync_prev_q  <= vsync_prev_d;
            frame_cnt_q   <= frame_cnt_d;
            cur_mode_q    <= cur_mode_d;
            thresh_q      <= thresh_d;
            pend_full_q   <= pend_full_d;
            pend_mode_q   <= pend_mode_d;
            pend_thresh_q <= pend_thresh_d;
            auto_cnt_q    <= auto_cnt_d;
            post_vsync_q  <= post_vsync_d;
            post_href_q   <= post_href_d;
            post_clken_q  <= post_clken_d;
            post_y_q      <= post_y_d;
        end
    end

    assign post_frame_vsync = post_vsync_q;
    assign post_frame_href  = post_href_q;
    assign post_frame_clken = post_clken_q;
    assign post_img_Y       = post_y_q;
    assign cur_mode         = cur_mode_q;
    assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_video_mode_scheduler.sv
// Bench for video_mode_scheduler: directed vector table, hand-written reset
// sequences, and randomized frames checked against a frame-level model.
module tb_video_mode_scheduler;

    localparam int AF = 2;

    typedef struct {
        logic       v, h, c;
        logic [7:0] y;
        logic       cv;
        logic [1:0] cm;
        logic [7:0] ct;
        logic       ae;
    } in_t;

    typedef struct {
        in_t         i;
        logic [7:0]  ey;
        logic [1:0]  em;
        logic [15:0] ecnt;
        logic        er;
    } vec_t;

    logic        clk, rst_n;
    logic        vsync, href, clken;
    logic [7:0]  y;
    logic        cfg_valid;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_thresh;
    logic        cfg_ready;
    logic        auto_en;
    logic        post_frame_vsync, post_frame_href, post_frame_clken;
    logic [7:0]  post_img_Y;
    logic [1:0]  cur_mode;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference state.
    bit m_synced, m_prev_v, m_pend;
    int m_mode, m_thresh, m_pmode, m_pthresh, m_auto, m_cnt;
    int e_v, e_h, e_c, e_y;

    vec_t tbl[$];

    video_mode_scheduler #(.AUTO_FRAMES(AF)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (vsync),
        .per_frame_href   (href),
        .per_frame_clken  (clken),
        .per_img_Y        (y),
        .cfg_valid        (cfg_valid),
        .cfg_mode         (cfg_mode),
        .cfg_thresh       (cfg_thresh),
        .cfg_ready        (cfg_ready),
        .auto_en          (auto_en),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y),
        .cur_mode         (cur_mode),
        .frame_cnt        (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_op(input int mode, input int th, input int yv);
        case (mode)
            0:       return yv;
            1:       return 255 - yv;
            2:       return (yv >= th) ? 255 : 0;
            default: return (yv >= th) ? 0 : 255;
        endcase
    endfunction

    function automatic in_t mk_in(input logic v, input logic h, input logic c, input logic [7:0] yv,
                                  input logic cv, input logic [1:0] cm, input logic [7:0] ct,
                                  input logic ae);
        in_t r;
        r.v = v; r.h = h; r.c = c; r.y = yv; r.cv = cv; r.cm = cm; r.ct = ct; r.ae = ae;
        return r;
    endfunction

    function automatic vec_t mk(input logic v, input logic c, input logic [7:0] yv,
                                input logic cv, input logic [1:0] cm, input logic [7:0] ct,
                                input logic ae, input logic [7:0] ey, input logic [1:0] em,
                                input logic [15:0] ecnt, input logic er);
        vec_t r;
        r.i = mk_in(v, c, c, yv, cv, cm, ct, ae);
        r.ey = ey; r.em = em; r.ecnt = ecnt; r.er = er;
        return r;
    endfunction

    task automatic model_reset();
        m_synced = 0; m_prev_v = 0; m_pend = 0;
        m_mode = 0; m_thresh = 128; m_pmode = 0; m_pthresh = 0; m_auto = 0; m_cnt = 0;
        e_v = 0; e_h = 0; e_c = 0; e_y = 0;
    endtask

    // One clock edge of the frame-level rules.
    task automatic model_update(input in_t i);
        bit fs, acc;
        fs  = m_synced && !m_prev_v && i.v;
        acc = i.cv && !m_pend;
        if (fs) begin
            m_cnt = (m_cnt + 1) % 65536;
            if (m_pend) begin
                m_mode = m_pmode; m_thresh = m_pthresh; m_pend = 0; m_auto = 0;
            end else if (i.ae && m_auto == AF - 1) begin
                m_mode = (m_mode + 1) % 4; m_auto = 0;
            end else if (i.ae) begin
                m_auto++;
            end
        end
        if (!i.ae) m_auto = 0;
        if (acc) begin
            m_pend = 1; m_pmode = int'(i.cm); m_pthresh = int'(i.ct);
        end
        if (!m_synced) begin
            e_v = 0; e_h = 0; e_c = 0; e_y = 0;
        end else begin
            e_v = i.v; e_h = i.h; e_c = i.c;
            e_y = i.c ? ref_op(m_mode, m_thresh, int'(i.y)) : 0;
        end
        if (!m_synced && !i.v) m_synced = 1;
        m_prev_v = i.v;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_post_vsync"}, 32'(post_frame_vsync), 32'(e_v));
        check({tag, "_post_href"},  32'(post_frame_href),  32'(e_h));
        check({tag, "_post_clken"}, 32'(post_frame_clken), 32'(e_c));
        check({tag, "_post_y"},     32'(post_img_Y),       32'(e_y));
        check({tag, "_cur_mode"},   32'(cur_mode),         32'(m_mode));
        check({tag, "_frame_cnt"},  32'(frame_cnt),        32'(m_cnt));
        check({tag, "_cfg_ready"},  32'(cfg_ready),        rst_n ? 32'(!m_pend) : 32'd0);
    endtask

    task automatic step(input in_t i, input string tag);
        vsync = i.v; href = i.h; clken = i.c; y = i.y;
        cfg_valid = i.cv; cfg_mode = i.cm; cfg_thresh = i.ct; auto_en = i.ae;
        @(posedge clk);
        model_update(i);
        #1;
        check_all(tag);
    endtask

    // Reset in the middle of a frame (vsync high), then resynchronise.
    task automatic do_reset();
        vsync = 1; href = 1; clken = 1; y = 8'h55; cfg_valid = 0; auto_en = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        rst_n = 1'b1;
        repeat (3) step(mk_in(1, 1, 1, 8'(($urandom)), 0, 0, 0, 0), "wait_sync");
        check("wait_sync_cnt", 32'(frame_cnt), 32'd0);
        check("wait_sync_y", 32'(post_img_Y), 32'd0);
        step(mk_in(0, 0, 0, 8'h00, 0, 0, 0, 0), "sync_low");
        step(mk_in(0, 0, 0, 8'h00, 0, 0, 0, 0), "idle");
        step(mk_in(1, 0, 0, 8'h00, 0, 0, 0, 0), "first_start");
        check("first_frame_cnt", 32'(frame_cnt), 32'd1);
    endtask

    initial begin
        bit hold, pre_pend;
        in_t ri;

        rst_n = 1'b1;
        vsync = 0; href = 0; clken = 0; y = 0;
        cfg_valid = 0; cfg_mode = 0; cfg_thresh = 0; auto_en = 0;
        #2;
        do_reset();

        //          v  c  y      cv cm ct     ae  ey     em cnt er
        tbl.push_back(mk(1, 1, 8'h3C, 0, 0, 8'd0,   0, 8'h3C, 0, 1,  1));
        tbl.push_back(mk(1, 1, 8'h3C, 1, 1, 8'h80,  0, 8'h3C, 0, 1,  0));
        tbl.push_back(mk(1, 1, 8'h3C, 0, 0, 8'd0,   0, 8'h3C, 0, 1,  0));
        tbl.push_back(mk(0, 0, 8'h3C, 0, 0, 8'd0,   0, 8'h00, 0, 1,  0));
        tbl.push_back(mk(1, 1, 8'h3C, 0, 0, 8'd0,   0, 8'hC3, 1, 2,  1));
        tbl.push_back(mk(1, 1, 8'h3C, 1, 2, 8'd100, 0, 8'hC3, 1, 2,  0));
        tbl.push_back(mk(1, 1, 8'd99, 0, 0, 8'd0,   0, 8'h9C, 1, 2,  0));
        tbl.push_back(mk(0, 0, 8'd99, 0, 0, 8'd0,   0, 8'h00, 1, 2,  0));
        tbl.push_back(mk(1, 1, 8'd99, 0, 0, 8'd0,   0, 8'h00, 2, 3,  1));
        tbl.push_back(mk(1, 1, 8'd100,0, 0, 8'd0,   0, 8'hFF, 2, 3,  1));
        tbl.push_back(mk(1, 0, 8'd0,  0, 0, 8'd0,   0, 8'h00, 2, 3,  1));
        tbl.push_back(mk(0, 0, 8'd0,  0, 0, 8'd0,   0, 8'h00, 2, 3,  1));
        tbl.push_back(mk(1, 1, 8'd100,1, 3, 8'd100, 0, 8'hFF, 2, 4,  0));
        tbl.push_back(mk(1, 1, 8'd100,0, 0, 8'd0,   0, 8'hFF, 2, 4,  0));
        tbl.push_back(mk(0, 0, 8'd100,0, 0, 8'd0,   0, 8'h00, 2, 4,  0));
        tbl.push_back(mk(1, 1, 8'd100,0, 0, 8'd0,   0, 8'h00, 3, 5,  1));
        tbl.push_back(mk(1, 1, 8'd50, 0, 0, 8'd0,   0, 8'hFF, 3, 5,  1));
        tbl.push_back(mk(1, 1, 8'd0,  1, 2, 8'd0,   0, 8'hFF, 3, 5,  0));
        tbl.push_back(mk(0, 0, 8'd0,  0, 0, 8'd0,   0, 8'h00, 3, 5,  0));
        tbl.push_back(mk(1, 1, 8'd0,  0, 0, 8'd0,   0, 8'hFF, 2, 6,  1));
        tbl.push_back(mk(1, 1, 8'hFF, 1, 2, 8'd255, 0, 8'hFF, 2, 6,  0));
        tbl.push_back(mk(0, 0, 8'hFF, 0, 0, 8'd0,   0, 8'h00, 2, 6,  0));
        tbl.push_back(mk(1, 1, 8'hFE, 0, 0, 8'd0,   0, 8'h00, 2, 7,  1));
        tbl.push_back(mk(1, 1, 8'hFF, 0, 0, 8'd0,   0, 8'hFF, 2, 7,  1));
        tbl.push_back(mk(1, 1, 8'h0A, 1, 1, 8'd255, 0, 8'h00, 2, 7,  0));
        tbl.push_back(mk(1, 1, 8'h0A, 1, 0, 8'd7,   0, 8'h00, 2, 7,  0));
        tbl.push_back(mk(0, 0, 8'h0A, 1, 0, 8'd7,   0, 8'h00, 2, 7,  0));
        tbl.push_back(mk(1, 1, 8'h0A, 1, 0, 8'd7,   0, 8'hF5, 1, 8,  1));
        tbl.push_back(mk(1, 1, 8'h0A, 1, 0, 8'd7,   0, 8'hF5, 1, 8,  0));
        tbl.push_back(mk(1, 1, 8'h0A, 0, 0, 8'd0,   0, 8'hF5, 1, 8,  0));
        tbl.push_back(mk(0, 0, 8'h0A, 0, 0, 8'd0,   0, 8'h00, 1, 8,  0));
        tbl.push_back(mk(1, 1, 8'h0A, 0, 0, 8'd0,   0, 8'h0A, 0, 9,  1));
        tbl.push_back(mk(1, 1, 8'h0A, 1, 3, 8'd7,   0, 8'h0A, 0, 9,  0));
        tbl.push_back(mk(0, 0, 8'h0A, 0, 0, 8'd0,   1, 8'h00, 0, 9,  0));
        tbl.push_back(mk(1, 1, 8'h0A, 0, 0, 8'd0,   1, 8'h00, 3, 10, 1));
        tbl.push_back(mk(0, 0, 8'h0A, 0, 0, 8'd0,   1, 8'h00, 3, 10, 1));
        tbl.push_back(mk(1, 1, 8'h0A, 0, 0, 8'd0,   1, 8'h00, 3, 11, 1));
        tbl.push_back(mk(0, 0, 8'h0A, 0, 0, 8'd0,   1, 8'h00, 3, 11, 1));
        tbl.push_back(mk(1, 1, 8'h0A, 0, 0, 8'd0,   1, 8'h0A, 0, 12, 1));
        tbl.push_back(mk(0, 0, 8'h0A, 0, 0, 8'd0,   1, 8'h00, 0, 12, 1));
        tbl.push_back(mk(1, 1, 8'h0A, 0, 0, 8'd0,   1, 8'h0A, 0, 13, 1));
        tbl.push_back(mk(0, 0, 8'h0A, 1, 2, 8'd7,   1, 8'h00, 0, 13, 0));
        tbl.push_back(mk(1, 1, 8'h0A, 0, 0, 8'd0,   1, 8'hFF, 2, 14, 1));
        tbl.push_back(mk(0, 0, 8'h0A, 0, 0, 8'd0,   1, 8'h00, 2, 14, 1));
        tbl.push_back(mk(1, 1, 8'h0A, 0, 0, 8'd0,   1, 8'hFF, 2, 15, 1));
        tbl.push_back(mk(0, 0, 8'h0A, 0, 0, 8'd0,   1, 8'h00, 2, 15, 1));
        tbl.push_back(mk(1, 1, 8'h0A, 0, 0, 8'd0,   1, 8'h00, 3, 16, 1));
        tbl.push_back(mk(0, 0, 8'h0A, 0, 0, 8'd0,   0, 8'h00, 3, 16, 1));

        foreach (tbl[k]) begin
            step(tbl[k].i, $sformatf("vec%0d_model", k));
            check($sformatf("vec%0d_post_y", k),    32'(post_img_Y), 32'(tbl[k].ey));
            check($sformatf("vec%0d_cur_mode", k),  32'(cur_mode),   32'(tbl[k].em));
            check($sformatf("vec%0d_frame_cnt", k), 32'(frame_cnt),  32'(tbl[k].ecnt));
            check($sformatf("vec%0d_cfg_ready", k), 32'(cfg_ready),  32'(tbl[k].er));
        end

        // Randomized frames; a refused request is held until accepted.
        hold = 0;
        ri = mk_in(0, 0, 0, 8'h00, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 11) == 0) ri.v = ~ri.v;
            ri.h = 1'($urandom);
            ri.c = ($urandom_range(0, 3) != 0);
            ri.y = 8'($urandom);
            if (n % 250 == 0) ri.ae = 1'($urandom);
            if (!hold) begin
                ri.cv = ($urandom_range(0, 3) == 0);
                ri.cm = 2'($urandom);
                ri.ct = 8'($urandom);
            end
            pre_pend = m_pend;
            step(ri, "rand");
            hold = ri.cv && pre_pend;
        end

        do_reset();
        step(mk_in(1, 1, 1, 8'h3C, 0, 0, 0, 0), "post_reset");
        check("post_reset_y", 32'(post_img_Y), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
